// File: rtl/bringup_pkg.sv
// bringup_pkg: shared state encoding, default parameters and stage-delay field extraction
package bringup_pkg;
  typedef enum logic [1:0] {IDLE, SEQ, RUN, TIMEOUT} state_t;
  localparam int DEF_NUM_STAGES = 2;
  localparam int DEF_DLY_W = 16;
  localparam int DEF_TMO_W = 32;
  localparam int DEF_AUTO_START = 1;
  localparam int MAX_STAGES = 8;
  localparam int MAX_DLY_W = 64;
  localparam int MAX_BUS = MAX_STAGES * MAX_DLY_W;
  function automatic logic [MAX_DLY_W-1:0] delay_field(input logic [MAX_BUS-1:0] bus,
                                                       input int unsigned i,
                                                       input int unsigned w);
    logic [MAX_BUS-1:0] mask;
    mask = (MAX_BUS'(1) << w) - MAX_BUS'(1);
    return MAX_DLY_W'((bus >> (i * w)) & mask);
  endfunction
endpackage

// File: rtl/bringup_stage_counter.sv
// bringup_stage_counter: per-stage edge counter, terminal count at max(delay,1) edges after load
module bringup_stage_counter #(
  parameter int DLY_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [DLY_W-1:0] delay,
  output logic             tc
);
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] eff;
  assign eff = delay == '0 ? DLY_W'(1) : delay;
  assign tc = cnt == eff - DLY_W'(1);
  // clear on reset or load, otherwise count edges and wrap to zero when the stage fires
  always_ff @(posedge clock) begin
    if (!reset_n || load) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + DLY_W'(1);
  end
endmodule

// File: rtl/bringup_sequencer.sv
// bringup_sequencer: staged release sequencer with run-phase cycle counter and timeout
module bringup_sequencer import bringup_pkg::*; #(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int DLY_W      = DEF_DLY_W,
  parameter int TMO_W      = DEF_TMO_W,
  parameter int AUTO_START = DEF_AUTO_START
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [NUM_STAGES*DLY_W-1:0] stage_delay,
  input  logic [TMO_W-1:0]            timeout_limit,
  output logic [NUM_STAGES-1:0]       stage_release,
  output logic                        busy,
  output logic                        done,
  output logic                        timed_out,
  output logic                        timeout_pulse,
  output logic [TMO_W-1:0]            run_cycles
);
  localparam int IDX_W = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  state_t                      state;
  logic                        auto_pending;
  logic [NUM_STAGES*DLY_W-1:0] dly_q;
  logic [IDX_W-1:0]            idx;
  logic [DLY_W-1:0]            cur_dly;
  logic                        go;
  logic                        cnt_en;
  logic                        tc;
  logic                        last;
  logic [TMO_W-1:0]            next_cycles;
  assign go          = start || (state == IDLE && auto_pending);
  assign cur_dly     = DLY_W'(delay_field(MAX_BUS'(dly_q), 32'(idx), 32'(DLY_W)));
  assign cnt_en      = state == SEQ && !go;
  assign last        = idx == IDX_W'(NUM_STAGES - 1);
  assign next_cycles = &run_cycles ? run_cycles : run_cycles + TMO_W'(1);
  bringup_stage_counter #(.DLY_W(DLY_W)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (go),
    .en      (cnt_en),
    .delay   (cur_dly),
    .tc      (tc)
  );
  // sequencer FSM: start always wins, otherwise release stages in order, then count run cycles
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      auto_pending  <= AUTO_START != 0;
      stage_release <= '0;
      idx           <= '0;
      dly_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timed_out     <= 1'b0;
      timeout_pulse <= 1'b0;
      run_cycles    <= '0;
    end else if (go) begin
      state         <= SEQ;
      auto_pending  <= 1'b0;
      stage_release <= '0;
      idx           <= '0;
      dly_q         <= stage_delay;
      busy          <= 1'b1;
      done          <= 1'b0;
      timed_out     <= 1'b0;
      timeout_pulse <= 1'b0;
      run_cycles    <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      if (state == SEQ && tc) begin
        stage_release[idx] <= 1'b1;
        idx <= last ? idx : idx + IDX_W'(1);
        if (last) begin
          state      <= RUN;
          busy       <= 1'b0;
          done       <= 1'b1;
          run_cycles <= '0;
        end
      end
      if (state == RUN) begin
        run_cycles <= next_cycles;
        if (timeout_limit != '0 && next_cycles >= timeout_limit) begin
          state         <= TIMEOUT;
          done          <= 1'b0;
          timed_out     <= 1'b1;
          timeout_pulse <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bringup_sequencer.sv
// tb_bringup_sequencer: directed and random checks against an event-time reference model
module tb_bringup_sequencer;
  localparam int NS = 2;
  localparam int DW = 16;
  localparam int TW = 32;
  logic clock, reset_n, start, start2;
  logic [NS*DW-1:0] stage_delay;
  logic [TW-1:0] timeout_limit;
  logic [NS-1:0] stage_release, stage_release2;
  logic busy, done, timed_out, timeout_pulse;
  logic busy2, done2, timed_out2, timeout_pulse2;
  logic [TW-1:0] run_cycles, run_cycles2;
  int n_assert, n_fail;
  bit active, pend, started2;
  int t, d0, d1;

  bringup_sequencer #(.NUM_STAGES(NS), .DLY_W(DW), .TMO_W(TW), .AUTO_START(1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stage_delay(stage_delay),
    .timeout_limit(timeout_limit), .stage_release(stage_release), .busy(busy), .done(done),
    .timed_out(timed_out), .timeout_pulse(timeout_pulse), .run_cycles(run_cycles));

  bringup_sequencer #(.NUM_STAGES(NS), .DLY_W(DW), .TMO_W(TW), .AUTO_START(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .stage_delay(stage_delay),
    .timeout_limit(timeout_limit), .stage_release(stage_release2), .busy(busy2), .done(done2),
    .timed_out(timed_out2), .timeout_pulse(timeout_pulse2), .run_cycles(run_cycles2));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rn, input logic st);
    int total, rc, lim;
    bit to;
    logic [NS-1:0] e_rel;
    logic e_busy, e_done, e_pulse;
    logic [31:0] e_rc;
    reset_n = rn;
    start = st;
    @(posedge clock);
    if (!rn) begin
      active = 0;
      pend = 1;
    end else if (st || pend) begin
      active = 1;
      pend = 0;
      t = 0;
      d0 = int'(stage_delay[DW-1:0]);
      d1 = int'(stage_delay[2*DW-1:DW]);
      if (d0 == 0) d0 = 1;
      if (d1 == 0) d1 = 1;
    end else if (active) t++;
    #1;
    e_rel = '0; e_busy = 0; e_done = 0; e_pulse = 0; e_rc = 0; to = 0;
    if (active) begin
      lim = int'(timeout_limit);
      total = d0 + d1;
      rc = t >= total ? t - total : 0;
      to = lim != 0 && t >= total && rc >= lim;
      e_rel = {t >= total, t >= d0};
      e_busy = t < total;
      e_done = t >= total && !to;
      e_pulse = to && rc == lim;
      e_rc = to ? lim : rc;
    end
    chk("release", 32'(stage_release), 32'(e_rel));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("timed_out", 32'(timed_out), 32'(to));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(e_pulse));
    chk("run_cycles", run_cycles, e_rc);
    if (!started2) begin
      chk("noauto_busy", 32'(busy2), 0);
      chk("noauto_release", 32'(stage_release2), 0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick(1, 0);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    active = 0; pend = 0; started2 = 0; t = 0; d0 = 1; d1 = 1;
    reset_n = 0; start = 0; start2 = 0;
    stage_delay = {16'd20, 16'd30};
    timeout_limit = 0;
    repeat (3) tick(0, 0);
    run(10);
    stage_delay = {16'd5, 16'd5};
    run(60);
    stage_delay = {16'd20, 16'd30};
    tick(1, 1); run(39); tick(1, 1); run(60);
    tick(1, 1); run(29); tick(1, 1); run(55);
    stage_delay = '0;
    tick(1, 1); run(5);
    stage_delay = {16'd1, 16'd1};
    timeout_limit = 1000;
    tick(1, 1); run(1010);
    timeout_limit = 0;
    stage_delay = {16'd20, 16'd30};
    tick(1, 1); run(60); tick(0, 0); run(60);
    for (int it = 0; it < 20; it++) begin
      stage_delay = {DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15))};
      timeout_limit = TW'($urandom_range(0, 30));
      tick(1, 1);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 7) == 0)
          stage_delay = {DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15))};
        tick($urandom_range(0, 199) != 0, $urandom_range(0, 39) == 0);
      end
    end
    started2 = 1;
    start2 = 1;
    tick(1, 0);
    start2 = 0;
    chk("noauto_start_busy", 32'(busy2), 1);
    chk("noauto_start_release", 32'(stage_release2), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
